// File: rtl/disp_pkg.sv
// Shared types and helpers for the BCD digit feeder: FSM states, decimal range
// limit and leading-zero blanking mask.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } feeder_state_t;

  localparam int unsigned MAX_DIG = 16;
  localparam int unsigned MAX_BCD = 4 * MAX_DIG;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic int unsigned pow10_m1(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  // Bit i set when digit i and all digits above it are zero; digit 0 is always drawn.
  function automatic logic [MAX_DIG-1:0] blank_mask(input logic [MAX_BCD-1:0] bcd,
                                                    input int unsigned n);
    logic [MAX_DIG-1:0] m;
    logic               zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int unsigned i = MAX_DIG - 1; i >= 1; i--) begin
      if (i < n) begin
        zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
        m[i]       = zero_above;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  always_comb begin
    dout_c = din;
    if (din >= 4'd5) begin
      dout_c = din + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_digit_feeder.sv
// Iterative binary-to-BCD converter with a frame-synchronous display register
// and leading-zero blanking mask for the character overlay.
module bcd_digit_feeder
  import disp_pkg::*;
#(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned NDIG  = 4
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              ready,
  input  logic              frame_start,
  output logic              done,
  output logic [NDIG*4-1:0] digits,
  output logic [NDIG-1:0]   blank,
  output logic              ovf
);

  localparam int unsigned BW    = NDIG * 4;
  localparam int unsigned MAXV  = pow10_m1(NDIG);
  localparam int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned VBITS = $clog2(MAXV + 1);
  localparam int unsigned NEED  = (WIDTH < VBITS) ? WIDTH : VBITS;
  localparam logic [NDIG-1:0] BLANK_RST = NDIG'(blank_mask('0, NDIG));

  // The BCD register must hold the largest value that can survive the clamp.
  if (BW < NEED) begin : g_width_check
    $error("bcd_digit_feeder: NDIG*4 too narrow for converted range");
  end

  feeder_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]   pending_q, pending_d;
  logic            pending_ovf_q, pending_ovf_d;
  logic            pending_valid_q, pending_valid_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [NDIG-1:0] blank_q, blank_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic [BW-1:0]   adj_c;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din    (bcd_q[4*g +: 4]),
      .dout_c (adj_c[4*g +: 4])
    );
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bin_d           = bin_q;
    bcd_d           = bcd_q;
    ovf_pend_d      = ovf_pend_q;
    pending_d       = pending_q;
    pending_ovf_d   = pending_ovf_q;
    pending_valid_d = pending_valid_q;
    digits_d        = digits_q;
    blank_d         = blank_q;
    ovf_d           = ovf_q;
    done_d          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          cnt_d   = CW'(WIDTH - 1);
          bcd_d   = '0;
          if (32'(value) > MAXV) begin
            bin_d      = WIDTH'(MAXV);
            ovf_pend_d = 1'b1;
          end else begin
            bin_d      = value;
            ovf_pend_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj_c, bin_q} << 1;
        cnt_d          = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = COMMIT;
          done_d  = 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Display update sees pending as it was before this edge.
    if (frame_start && pending_valid_q) begin
      digits_d        = pending_q;
      ovf_d           = pending_ovf_q;
      blank_d         = NDIG'(blank_mask(MAX_BCD'(pending_q), NDIG));
      pending_valid_d = 1'b0;
    end

    // A fresh result always wins over a same-edge display commit.
    if (state_q == COMMIT) begin
      pending_d       = bcd_q;
      pending_ovf_d   = ovf_pend_q;
      pending_valid_d = 1'b1;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bin_q           <= '0;
      bcd_q           <= '0;
      ovf_pend_q      <= 1'b0;
      pending_q       <= '0;
      pending_ovf_q   <= 1'b0;
      pending_valid_q <= 1'b0;
      digits_q        <= '0;
      blank_q         <= BLANK_RST;
      ovf_q           <= 1'b0;
      done_q          <= 1'b0;
      ready_q         <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bin_q           <= bin_d;
      bcd_q           <= bcd_d;
      ovf_pend_q      <= ovf_pend_d;
      pending_q       <= pending_d;
      pending_ovf_q   <= pending_ovf_d;
      pending_valid_q <= pending_valid_d;
      digits_q        <= digits_d;
      blank_q         <= blank_d;
      ovf_q           <= ovf_d;
      done_q          <= done_d;
      ready_q         <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign digits = digits_q;
  assign blank  = blank_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Scoreboard bench for bcd_digit_feeder: stimulus queues expected done cycles and
// expected display contents; a monitor compares whenever done or a frame commit occurs.
module tb_bcd_digit_feeder;

  localparam int unsigned WIDTH = 14;
  localparam int unsigned NDIG  = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  b;
    logic        o;
  } disp_t;

  logic              clk_pix = 1'b0;
  logic              rst_pix = 1'b1;
  logic [WIDTH-1:0]  value = '0;
  logic              load = 1'b0;
  logic              ready;
  logic              frame_start = 1'b0;
  logic              done;
  logic [NDIG*4-1:0] digits;
  logic [NDIG-1:0]   blank;
  logic              ovf;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_load = 0;
  logic  fs_at_edge = 1'b0;
  int    exp_done_q[$];
  disp_t exp_disp_q[$];

  bcd_digit_feeder #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .value       (value),
    .load        (load),
    .ready       (ready),
    .frame_start (frame_start),
    .done        (done),
    .digits      (digits),
    .blank       (blank),
    .ovf         (ovf)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk_pix) begin
    cyc        <= cyc + 1;
    fs_at_edge <= frame_start & ~rst_pix;
  end

  // Monitor: done pulses and frame commits are checked against the queues.
  always @(negedge clk_pix) begin
    if (!rst_pix) begin
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          check("done_cycle", 32'(cyc), 32'(exp_done_q.pop_front()));
        end
      end
      if (fs_at_edge) begin
        if (exp_disp_q.size() == 0) begin
          check("disp_unexpected", 32'd1, 32'd0);
        end else begin
          disp_t e;
          e = exp_disp_q.pop_front();
          check("digits", 32'(digits), 32'(e.d));
          check("blank",  32'(blank),  32'(e.b));
          check("ovf",    32'(ovf),    32'(e.o));
        end
      end
    end
  end

  task automatic do_load(input int v, input bit accept);
    value = WIDTH'(v);
    load  = 1'b1;
    if (accept) begin
      last_load = cyc + 1;
      exp_done_q.push_back(last_load + int'(WIDTH));
    end
    @(negedge clk_pix);
    load = 1'b0;
    if (accept) check("ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic wait_ready(input bit check_lat);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk_pix);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    else if (check_lat) check("ready_cycle", 32'(cyc), 32'(last_load + int'(WIDTH) + 1));
  endtask

  task automatic frame(input logic [15:0] d, input logic [3:0] b, input logic o);
    disp_t e;
    e.d = d;
    e.b = b;
    e.o = o;
    exp_disp_q.push_back(e);
    frame_start = 1'b1;
    @(negedge clk_pix);
    frame_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_pix);
    rst_pix = 1'b0;
    @(negedge clk_pix);
    check("rst_digits", 32'(digits), 32'h0000);
    check("rst_blank",  32'(blank),  32'hE);
    check("rst_ovf",    32'(ovf),    32'd0);
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_done",   32'(done),   32'd0);

    do_load(1234, 1'b1); wait_ready(1'b1); frame(16'h1234, 4'b0000, 1'b0);
    do_load(7, 1'b1);    wait_ready(1'b1); frame(16'h0007, 4'b1110, 1'b0);
    do_load(0, 1'b1);    wait_ready(1'b1); frame(16'h0000, 4'b1110, 1'b0);
    do_load(12000, 1'b1); wait_ready(1'b1); frame(16'h9999, 4'b0000, 1'b1);
    do_load(42, 1'b1);   wait_ready(1'b1); frame(16'h0042, 4'b1100, 1'b0);

    // Load during conversion is dropped.
    do_load(55, 1'b1);
    repeat (3) @(negedge clk_pix);
    do_load(99, 1'b0);
    wait_ready(1'b1);
    frame(16'h0055, 4'b1100, 1'b0);

    // frame_start coincides with the COMMIT edge: display unchanged this frame.
    do_load(888, 1'b1);
    repeat (WIDTH) @(negedge clk_pix);
    frame(16'h0055, 4'b1100, 1'b0);
    wait_ready(1'b0);
    frame(16'h0888, 4'b1000, 1'b0);
    frame(16'h0888, 4'b1000, 1'b0);

    // Latest pending result wins.
    do_load(1, 1'b1); wait_ready(1'b1);
    do_load(2, 1'b1); wait_ready(1'b1);
    frame(16'h0002, 4'b1110, 1'b0);

    // Reset mid-conversion.
    do_load(321, 1'b1); wait_ready(1'b1); frame(16'h0321, 4'b1000, 1'b0);
    do_load(5, 1'b1);
    repeat (4) @(negedge clk_pix);
    rst_pix = 1'b1;
    void'(exp_done_q.pop_back());
    @(negedge clk_pix);
    check("mid_rst_digits", 32'(digits), 32'h0000);
    check("mid_rst_blank",  32'(blank),  32'hE);
    check("mid_rst_ovf",    32'(ovf),    32'd0);
    check("mid_rst_ready",  32'(ready),  32'd1);
    rst_pix = 1'b0;
    @(negedge clk_pix);
    do_load(321, 1'b1); wait_ready(1'b1); frame(16'h0321, 4'b1000, 1'b0);

    repeat (20) @(negedge clk_pix);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    check("disp_queue_empty", 32'(exp_disp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
